seg7_monitor: RTL and testbench

Capture-side counterpart of the processor's two-digit seven-segment output: samples the `Tens`/`Ones` segment buses, waits for them to settle, decodes them back to a binary value 0..99, and queues each new settled value in a small FIFO read out over a valid/ready handshake. It sits beside the processor top in simulation and on-board self-check builds, turning display activity into a readable log of results.

---
 rtl/seg7_mon_pkg.sv | 43 ++++
 rtl/seg7_mon_fifo.sv | 46 ++++
 rtl/seg7_monitor.sv | 111 +++++++++++
 tb/tb_seg7_monitor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_mon_pkg.sv
// Shared constants, log entry type and digit decoder for seg7_monitor.
// SEG7_MON_TIMESTAMP_EN adds a 16-bit commit timestamp to each entry.
package seg7_mon_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] ERR_VALUE = 7'd127;

  typedef struct packed {
    logic       err;
    logic [6:0] value;
`ifdef SEG7_MON_TIMESTAMP_EN
    logic [15:0] stamp;
`endif
  } entry_t;

  // Returns {ok, digit}; ok=0 for anything that is not a lit digit 0..9.
  function automatic logic [4:0] seg_digit(input logic [6:0] pat);
    case (pat)
      SEG_0:   return {1'b1, 4'd0};
      SEG_1:   return {1'b1, 4'd1};
      SEG_2:   return {1'b1, 4'd2};
      SEG_3:   return {1'b1, 4'd3};
      SEG_4:   return {1'b1, 4'd4};
      SEG_5:   return {1'b1, 4'd5};
      SEG_6:   return {1'b1, 4'd6};
      SEG_7:   return {1'b1, 4'd7};
      SEG_8:   return {1'b1, 4'd8};
      SEG_9:   return {1'b1, 4'd9};
      default: return 5'b0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_mon_fifo.sv
// First-word fall-through FIFO; head is visible whenever not empty, zero otherwise.
module seg7_mon_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_pop, do_push;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same edge, so a full FIFO still takes the push.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/seg7_monitor.sv
// Samples two seven-segment digits, waits for them to settle and logs each new value.
// SEG7_MON_TIMESTAMP_EN adds out_stamp, the cycle count captured at commit.
module seg7_monitor
  import seg7_mon_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          Reset,
  input  logic [6:0]                    Tens,
  input  logic [6:0]                    Ones,
  input  logic                          out_ready,
  input  logic                          clr_overflow,
  output logic                          out_valid,
  output logic [6:0]                    out_value,
  output logic                          out_err,
  output logic [$clog2(FIFO_DEPTH):0]   level,
`ifdef SEG7_MON_TIMESTAMP_EN
  output logic [15:0]                   out_stamp,
`endif
  output logic                          overflow
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [6:0] samp_tens, samp_ones, last_tens, last_ones;
  logic [7:0] cnt;
  logic       none_yet, differs, commit;
  logic       push_q, pop, empty, full, drop;
  logic [4:0] dig_tens, dig_ones;
  entry_t     entry, entry_q, head;

  assign differs = {Tens, Ones} != {samp_tens, samp_ones};
  assign commit  = (cnt == CNT_MAX) &&
                   (none_yet || {samp_tens, samp_ones} != {last_tens, last_ones});

`ifdef SEG7_MON_TIMESTAMP_EN
  logic [15:0] stamp;
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) stamp <= '0;
    else        stamp <= stamp + 16'd1;
  end
  assign out_stamp = head.stamp;
`endif

  // A blank tens digit is a suppressed leading zero; a blank ones digit is not.
  always_comb begin
    entry    = '0;
    dig_tens = (samp_tens == SEG_BLANK) ? {1'b1, 4'd0} : seg_digit(samp_tens);
    dig_ones = seg_digit(samp_ones);
    entry.err   = !(dig_tens[4] && dig_ones[4]);
    entry.value = entry.err ? ERR_VALUE
                            : {3'b0, dig_tens[3:0]} * 7'd10 + {3'b0, dig_ones[3:0]};
`ifdef SEG7_MON_TIMESTAMP_EN
    entry.stamp = stamp;
`endif
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      samp_tens <= SEG_BLANK;
      samp_ones <= SEG_BLANK;
      last_tens <= SEG_BLANK;
      last_ones <= SEG_BLANK;
      cnt       <= '0;
      none_yet  <= 1'b1;
      push_q    <= 1'b0;
      entry_q   <= '0;
      overflow  <= 1'b0;
    end else begin
      samp_tens <= Tens;
      samp_ones <= Ones;
      if (differs)              cnt <= '0;
      else if (cnt != CNT_MAX)  cnt <= cnt + 8'd1;
      push_q <= commit;
      // Last-committed pair tracks commits even when the push is later dropped.
      if (commit) begin
        entry_q   <= entry;
        last_tens <= samp_tens;
        last_ones <= samp_ones;
        none_yet  <= 1'b0;
      end
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  assign pop  = out_valid && out_ready;
  assign drop = push_q && full && !pop;

  seg7_mon_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (Reset),
    .push  (push_q),
    .din   (entry_q),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  assign out_valid = !empty;
  assign out_value = head.value;
  assign out_err   = head.err;

endmodule

// File: tb/tb_seg7_monitor.sv
// Scoreboard bench for seg7_monitor: run-length reference model feeds an expected queue,
// a negedge monitor pops and compares on every accepted output.
module tb_seg7_monitor;

  localparam int S = 4;
  localparam int D = 8;
  localparam logic [6:0] BLANK = 7'h7F;

  typedef struct packed {
    logic       err;
    logic [6:0] value;
  } exp_t;

  logic       clk = 1'b0;
  logic       Reset;
  logic [6:0] tens, ones;
  logic       out_ready, clr_overflow;
  logic       out_valid, out_err, overflow;
  logic [6:0] out_value;
  logic [$clog2(D):0] level;
`ifdef SEG7_MON_TIMESTAMP_EN
  logic [15:0] out_stamp;
`endif

  seg7_monitor #(.STABLE_CYCLES(S), .FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .Tens         (tens),
    .Ones         (ones),
    .out_ready    (out_ready),
    .clr_overflow (clr_overflow),
    .out_valid    (out_valid),
    .out_value    (out_value),
    .out_err      (out_err),
    .level        (level),
`ifdef SEG7_MON_TIMESTAMP_EN
    .out_stamp    (out_stamp),
`endif
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  logic [6:0] pat [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                           7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int digit_of(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (pat[i] == p) return i;
    return -1;
  endfunction

  function automatic exp_t expect_of(input logic [13:0] pair);
    int t, o;
    exp_t e;
    t = (pair[13:7] == BLANK) ? 0 : digit_of(pair[13:7]);
    o = digit_of(pair[6:0]);
    if (t < 0 || o < 0) begin
      e.err = 1'b1; e.value = 7'd127;
    end else begin
      e.err = 1'b0; e.value = 7'(t * 10 + o);
    end
    return e;
  endfunction

  // Reference model: a pair commits once it has been seen for S consecutive samples
  // and is new; the entry reaches the log one edge later.
  exp_t        sb[$];
  int          mlevel;
  bit          movf;
  logic [13:0] cur, last;
  int          run;
  bit          none;
  bit          pend_v;
  exp_t        pend_e;

  always @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sb.delete();
      mlevel = 0; movf = 0; cur = 14'h3FFF; run = 1; none = 1; pend_v = 0;
    end else begin
      bit pop_m, push_ok, drop_m;
      pop_m   = (mlevel > 0) && out_ready;
      push_ok = pend_v && (mlevel < D || pop_m);
      drop_m  = pend_v && !push_ok;
      if (push_ok) sb.push_back(pend_e);
      mlevel = mlevel + int'(push_ok) - int'(pop_m);
      if (drop_m) movf = 1;
      else if (clr_overflow) movf = 0;
      pend_v = 0;
      if (run >= S && (none || cur != last)) begin
        pend_v = 1; pend_e = expect_of(cur); last = cur; none = 0;
      end
      if ({tens, ones} == cur) run = (run < 1000) ? run + 1 : run;
      else begin cur = {tens, ones}; run = 1; end
    end
  end

  always @(negedge clk) begin
    if (Reset) begin
      chk("out_valid", int'(out_valid), int'(mlevel > 0));
      chk("level", int'(level), mlevel);
      chk("overflow", int'(overflow), int'(movf));
      if (out_valid && out_ready) begin
        chk("sb_nonempty", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("head_value", int'(out_value), int'(e.value));
          chk("head_err", int'(out_err), int'(e.err));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set(input int t, input int o);
    tens = pat[t]; ones = pat[o];
  endtask

  function automatic logic [6:0] pick();
    int r;
    r = $urandom_range(0, 11);
    if (r < 10) return pat[r];
    if (r == 10) return BLANK;
    return 7'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    Reset = 1'b0; tens = BLANK; ones = pat[7]; out_ready = 1'b1; clr_overflow = 1'b0;
    cyc(2);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_value", int'(out_value), 0);
    chk("rst_err", int'(out_err), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_overflow", int'(overflow), 0);

    // Blank/7: count edges from release until the entry shows.
    Reset = 1'b1;
    lat = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = e; break; end
    end
    chk("latency_edges", lat, S + 2);
    cyc(4);

    // Settled 42, short glitch to 43, back to 42, then 99.
    set(4, 2); cyc(8);
    set(4, 3); cyc(2);
    set(4, 2); cyc(8);
    set(9, 9); cyc(8);

    // Invalid tens pattern.
    tens = 7'b1111110; ones = pat[0]; cyc(8);

    // Nine commits into a depth-8 log with the consumer stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin set(1, i); cyc(S + 2); end
    cyc(3);
    chk("full_level", int'(level), 8);
    chk("full_overflow", int'(overflow), 1);
    clr_overflow = 1'b1; cyc(1); clr_overflow = 1'b0;
    chk("clr_overflow", int'(overflow), 0);

    // Commit landing on the same edge as a pop of a full log.
    set(2, 5); cyc(S + 1);
    out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    chk("coincide_level", int'(level), 8);
    chk("coincide_overflow", int'(overflow), 0);
    out_ready = 1'b1; cyc(12);

    // Reset with entries queued, then the held pair is logged again.
    out_ready = 1'b0;
    set(3, 3); cyc(6);
    set(5, 6); cyc(6);
    set(8, 1); cyc(6);
    chk("queued_level", int'(level), 3);
    Reset = 1'b0; #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_level", int'(level), 0);
    cyc(1);
    Reset = 1'b1;
    cyc(S + 2);
    chk("relog_valid", int'(out_valid), 1);
    chk("relog_value", int'(out_value), 81);
    out_ready = 1'b1; cyc(3);

    // Random pairs, hold times, back-pressure and overflow clears.
    for (int i = 0; i < 300; i++) begin
      tens = pick(); ones = pick();
      repeat ($urandom_range(1, 7)) begin
        out_ready    = ($urandom_range(0, 9) < 7);
        clr_overflow = ($urandom_range(0, 19) == 0);
        cyc(1);
      end
    end
    clr_overflow = 1'b0; out_ready = 1'b1;
    cyc(20);
    chk("drained_level", int'(level), 0);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
